// File: rtl/msx_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msx_mem_pkg
// Brief    : Shared types and constants for the MSX SDRAM memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package msx_mem_pkg;

  // SDRAM byte address width seen by the slot/mapper stage.
  localparam int MEM_ADDR_W = 27;

  // Arbiter states: idle, serving a CPU cycle, serving a flash program write.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_CPU   = 2'd1,
    ARB_FLASH = 2'd2
  } mem_arb_state_t;

  // One captured memory access, used for both the CPU and flash capture registers.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [7:0]            din;
    logic                  we;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/msx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : msx_mem_arbiter
// Brief    : Merges CPU memory cycles and flash program writes onto a single
//            request/acknowledge SDRAM port. CPU has priority; the CPU is held
//            in wait while its access is outstanding; a watchdog aborts
//            accesses that never see an acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module msx_mem_arbiter
  import msx_mem_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_ce,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_din,
  input  logic              i_cpu_rnw,
  output logic [7:0]        o_cpu_dout,
  output logic              o_cpu_wait,
  input  logic              i_flash_req,
  input  logic [ADDR_W-1:0] i_flash_addr,
  input  logic [7:0]        i_flash_din,
  output logic              o_flash_ready,
  output logic              o_flash_done,
  output logic              o_sdram_req,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [7:0]        o_sdram_din,
  output logic              o_sdram_we,
  input  logic              i_sdram_ack,
  input  logic [7:0]        i_sdram_dout
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_arb_state_t     r_state;
  logic               r_cpu_ce_q;
  logic               r_cpu_pend;
  logic               r_flash_pend;
  mem_req_t           r_cpu_cap;
  mem_req_t           r_flash_cap;
  mem_req_t           r_sdram;
  logic               r_sdram_req;
  logic [7:0]         r_cpu_dout;
  logic               r_flash_done;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_cpu_edge;
  logic               w_flash_ready;
  logic               w_flash_accept;
  logic               w_cnt_last;
  mem_req_t           w_cpu_new;
  mem_req_t           w_flash_new;

  assign w_cpu_edge     = i_cpu_ce & ~r_cpu_ce_q;
  assign w_flash_ready  = ~r_flash_pend & (r_state != ARB_FLASH);
  assign w_flash_accept = i_flash_req & w_flash_ready;
  assign w_cnt_last     = (r_cnt == c_CNT_LAST);

  // The CPU fields are taken live in the edge cycle so an idle arbiter can
  // issue the request on the very next clock.
  assign w_cpu_new   = '{addr: MEM_ADDR_W'(i_cpu_addr), din: i_cpu_din, we: ~i_cpu_rnw};
  assign w_flash_new = '{addr: MEM_ADDR_W'(i_flash_addr), din: i_flash_din, we: 1'b1};

  assign o_cpu_wait    = w_cpu_edge | r_cpu_pend | (r_state == ARB_CPU);
  assign o_cpu_dout    = r_cpu_dout;
  assign o_flash_ready = w_flash_ready;
  assign o_flash_done  = r_flash_done;
  assign o_sdram_req   = r_sdram_req;
  assign o_sdram_addr  = ADDR_W'(r_sdram.addr);
  assign o_sdram_din   = r_sdram.din;
  assign o_sdram_we    = r_sdram.we;

  // Edge detect, capture registers, arbitration FSM and watchdog.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ARB_IDLE;
      r_cpu_ce_q   <= 1'b0;
      r_cpu_pend   <= 1'b0;
      r_flash_pend <= 1'b0;
      r_cpu_cap    <= '0;
      r_flash_cap  <= '0;
      r_sdram      <= '0;
      r_sdram_req  <= 1'b0;
      r_cpu_dout   <= 8'hFF;
      r_flash_done <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_cpu_ce_q   <= i_cpu_ce;
      r_flash_done <= 1'b0;

      // A CPU edge during its own access cannot happen (CPU is stalled), so
      // capture is only done outside ARB_CPU.
      if (w_cpu_edge && (r_state != ARB_CPU)) begin
        r_cpu_pend <= 1'b1;
        r_cpu_cap  <= w_cpu_new;
      end

      if (w_flash_accept) begin
        r_flash_pend <= 1'b1;
        r_flash_cap  <= w_flash_new;
      end

      case (r_state)
        ARB_IDLE: begin
          r_cnt <= '0;
          if (r_cpu_pend || w_cpu_edge) begin
            r_state     <= ARB_CPU;
            r_sdram_req <= 1'b1;
            r_sdram     <= r_cpu_pend ? r_cpu_cap : w_cpu_new;
          end else if (r_flash_pend) begin
            r_state     <= ARB_FLASH;
            r_sdram_req <= 1'b1;
            r_sdram     <= r_flash_cap;
          end
        end

        ARB_CPU: begin
          if (i_sdram_ack || w_cnt_last) begin
            r_state     <= ARB_IDLE;
            r_sdram_req <= 1'b0;
            r_cpu_pend  <= 1'b0;
            // Reads return the SDRAM byte, or open-bus 0xFF on a watchdog abort.
            if (!r_sdram.we) begin
              r_cpu_dout <= i_sdram_ack ? i_sdram_dout : 8'hFF;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ARB_FLASH: begin
          if (i_sdram_ack || w_cnt_last) begin
            r_state      <= ARB_IDLE;
            r_sdram_req  <= 1'b0;
            r_flash_pend <= 1'b0;
            r_flash_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state     <= ARB_IDLE;
          r_sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/msx_mem_arbiter.md
Name: msx_mem_arbiter

Overview:
- Downstream consumer of the slot/mapper stage's SDRAM-side outputs (sdram_ce, ram_addr, ram_din, ram_rnw, ram_dout) and flash programming outputs (flash_addr, flash_din, flash_req, flash_ready, flash_done).
- Merges CPU memory cycles and flash-program writes onto one request/acknowledge SDRAM port.
- Holds CPU wait while an access is outstanding, with a watchdog timeout.
- CPU accesses have priority over flash writes.

Parameters:
ADDR_W, 27, SDRAM byte address width.
TIMEOUT_CYCLES, 64, clk cycles without sdram_ack before an access is aborted; minimum 2.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous active-high reset.
cpu_ce  in  1  level; high for the duration of a CPU SDRAM memory cycle (slot stage sdram_ce).
cpu_addr  in  ADDR_W  CPU-side byte address (slot stage ram_addr).
cpu_din  in  8  CPU write data.
cpu_rnw  in  1  1 = read, 0 = write (write-protect already folded in upstream).
cpu_dout  out  8  last read data returned to slot stage (ram_dout).
cpu_wait  out  1  stall request to CPU wait logic.
flash_req  in  1  one-cycle pulse: program one byte.
flash_addr  in  ADDR_W  flash write address.
flash_din  in  8  flash write data.
flash_ready  out  1  arbiter can accept flash_req.
flash_done  out  1  one-cycle pulse when a flash write completes or times out.
sdram_req  out  1  access request, held until ack.
sdram_addr  out  ADDR_W  access address.
sdram_din  out  8  write data.
sdram_we  out  1  1 = write.
sdram_ack  in  1  one-cycle completion pulse from SDRAM controller.
sdram_dout  in  8  read data, valid in the sdram_ack cycle.

Behaviour:
Reset values (asynchronous, active-high):
- cpu_dout=8'hFF, cpu_wait=0, flash_ready=1, flash_done=0.
- sdram_req=0, sdram_addr=0, sdram_din=0, sdram_we=0.
- State IDLE, both pending flags clear, timeout counter 0.
- Reset asserted mid-access drops sdram_req immediately; nothing is retried after release.

CPU edge detection and wait:
- cpu_ce is registered; the rising edge sets cpu_pend and captures cpu_addr, cpu_din and cpu_rnw in the same cycle.
- cpu_wait is combinational from that edge: cpu_ce & ~cpu_ce_q | cpu_pend | (state==CPU_ACC).
- cpu_wait deasserts in the cycle after the ack.

Flash acceptance:
- flash_req while flash_ready=1 sets flash_pend and captures flash_addr and flash_din.
- flash_ready=0 while flash_pend is set or state==FLASH_ACC.
- flash_req while flash_ready=0 is ignored.

State machine (IDLE, CPU_ACC, FLASH_ACC):
- IDLE: if cpu_pend, go to CPU_ACC and drive sdram_req=1 with the captured CPU fields. Else if flash_pend, go to FLASH_ACC with sdram_req=1, sdram_we=1. CPU wins when both are pending, including same-cycle arrival.
- CPU_ACC: on sdram_ack, drop sdram_req, clear cpu_pend, and load cpu_dout<=sdram_dout if read (writes leave cpu_dout unchanged). Return to IDLE.
- FLASH_ACC: on sdram_ack, drop sdram_req, clear flash_pend, pulse flash_done for 1 cycle, return to IDLE.

Handshake rules:
- sdram_addr, sdram_din and sdram_we stay stable while sdram_req=1.
- Minimum one IDLE cycle between accesses; back-to-back requests are separated by one req-low cycle.
- Best-case latency: CPU edge at cycle 0, sdram_req at cycle 1, ack at cycle N, wait deasserts at N+1.

Timeout:
- The counter increments each cycle in CPU_ACC or FLASH_ACC and clears on state entry.
- At TIMEOUT_CYCLES-1 without ack: drop sdram_req and return to IDLE.
  - CPU read abort: cpu_dout<=8'hFF.
  - Flash abort: flash_done still pulses.
- Counter width is $clog2(TIMEOUT_CYCLES) bits.

Other boundary conditions:
- A new cpu_ce edge while a flash access is in flight is held pending and served next.
- A cpu_ce edge while CPU_ACC is busy cannot occur (CPU is stalled); it is not queued further.
- sdram_ack outside CPU_ACC/FLASH_ACC is ignored.

Decomposition:
- Shared package msx_mem_pkg holds:
  - mem_arb_state_t enum {ARB_IDLE, ARB_CPU, ARB_FLASH}.
  - MEM_ADDR_W=27.
  - typedef mem_req_t {addr, din, we} used for both capture registers.
- No sub-module: the edge detector, capture registers and FSM stay in one module.

Test Plan:
- CPU read: cpu_ce rises with cpu_addr=27'h0012345, cpu_rnw=1; ack at cycle 4 with sdram_dout=8'hA5 -> sdram_req cycles 1-4, sdram_we=0, cpu_wait cycles 0-4, cpu_dout=8'hA5 from cycle 5.
- CPU write: cpu_din=8'h3C, cpu_rnw=0 -> sdram_we=1, sdram_din=8'h3C; cpu_dout unchanged after ack.
- Flash write: flash_req pulse with flash_addr=27'h0100000, flash_din=8'h55 -> flash_ready=0 until ack; flash_done is one 1-cycle pulse in the cycle after ack; flash_ready=1 afterwards.
- Simultaneous cpu_ce edge and flash_req -> CPU access issued first; flash access issued after one IDLE cycle; both complete.
- No ack, TIMEOUT_CYCLES=64, CPU read -> sdram_req drops after 64 cycles; cpu_dout=8'hFF; cpu_wait released; next access proceeds normally.
- Reset asserted during FLASH_ACC -> sdram_req=0 and flash_ready=1 immediately, no flash_done pulse, no access after release.
